// File: rtl/armleocpu_axi_memcpy.sv
// AXI4 block-copy initiator: read a chunk into a local buffer, then write it out.
// Define ARMLEOCPU_MEMCPY_4K_SPLIT_EN to also split chunks at 4 KB boundaries.
module armleocpu_axi_memcpy #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [15:0]           cmd_words,
  output logic                  done_valid,
  output logic                  done_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic [ID_WIDTH-1:0]   axi_arid,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic [31:0]           axi_rdata,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wlast,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  input  logic [ID_WIDTH-1:0]   axi_bid
);

  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [16:0] MB = 17'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE, AR, R, AW, W, B, DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [15:0]           rem_q;
  logic [IW-1:0]         beat_q;
  logic                  err_q;
  logic                  cmd_ready_q, done_valid_q, done_err_q;
  logic                  arvalid_q, rready_q;
  logic                  awvalid_q, wvalid_q, bready_q;
  logic [31:0]           buf_q [MAX_BURST];
  logic [16:0]           chunk_d;
  logic                  last_d, rerr_d, berr_d;
  logic                  unused_ids;

`ifdef ARMLEOCPU_MEMCPY_4K_SPLIT_EN
  logic [10:0] src_room, dst_room;
  assign src_room = 11'h400 - {1'b0, src_q[11:2]};
  assign dst_room = 11'h400 - {1'b0, dst_q[11:2]};
  always_comb begin
    chunk_d = {1'b0, rem_q};
    if (chunk_d > MB) chunk_d = MB;
    if (chunk_d > {6'd0, src_room}) chunk_d = {6'd0, src_room};
    if (chunk_d > {6'd0, dst_room}) chunk_d = {6'd0, dst_room};
  end
`else
  always_comb begin
    chunk_d = {1'b0, rem_q};
    if (chunk_d > MB) chunk_d = MB;
  end
`endif

  assign last_d = ({{(17-IW){1'b0}}, beat_q} == chunk_d - 17'd1);
  assign rerr_d = (axi_rresp != 2'b00);
  assign berr_d = (axi_bresp != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            src_q       <= cmd_src;
            dst_q       <= cmd_dst;
            rem_q       <= cmd_words;
            err_q       <= 1'b0;
            if (cmd_words == 16'd0) begin
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b0;
            end else begin
              state_q   <= AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        AR: if (axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          beat_q    <= '0;
          state_q   <= R;
        end
        R: if (axi_rvalid) begin
          beat_q <= beat_q + 1'b1;
          if (rerr_d) err_q <= 1'b1;
          // A failed or truncated read chunk is never written out
          if (axi_rlast) begin
            rready_q <= 1'b0;
            if (err_q || rerr_d || !last_d) begin
              err_q        <= 1'b1;
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
            end else begin
              state_q   <= AW;
              awvalid_q <= 1'b1;
            end
          end
        end
        AW: if (axi_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          beat_q    <= '0;
          state_q   <= W;
        end
        W: if (axi_wready) begin
          beat_q <= beat_q + 1'b1;
          if (last_d) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: if (axi_bvalid) begin
          bready_q <= 1'b0;
          src_q    <= src_q + (ADDR_WIDTH'(chunk_d) << 2);
          dst_q    <= dst_q + (ADDR_WIDTH'(chunk_d) << 2);
          rem_q    <= rem_q - chunk_d[15:0];
          if (berr_d) err_q <= 1'b1;
          if (berr_d || rem_q == chunk_d[15:0]) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= err_q || berr_d;
          end else begin
            state_q   <= AR;
            arvalid_q <= 1'b1;
          end
        end
        DONE: begin
          done_valid_q <= 1'b0;
          done_err_q   <= 1'b0;
          cmd_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == R && axi_rvalid) buf_q[beat_q] <= axi_rdata;
  end

  assign cmd_ready   = cmd_ready_q;
  assign done_valid  = done_valid_q;
  assign done_err    = done_err_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = src_q;
  assign axi_arlen   = chunk_d[7:0] - 8'd1;
  assign axi_arsize  = 3'd2;
  assign axi_arburst = 2'b01;
  assign axi_arid    = ID_WIDTH'(AXI_ID);
  assign axi_rready  = rready_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = dst_q;
  assign axi_awlen   = chunk_d[7:0] - 8'd1;
  assign axi_awsize  = 3'd2;
  assign axi_awburst = 2'b01;
  assign axi_awid    = ID_WIDTH'(AXI_ID);
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = buf_q[beat_q];
  assign axi_wstrb   = 4'hF;
  assign axi_wlast   = last_d;
  assign axi_bready  = bready_q;
  assign unused_ids  = ^{axi_rid, axi_bid};

endmodule

// File: tb/tb_armleocpu_axi_memcpy.sv
// Scoreboard bench for armleocpu_axi_memcpy with a behavioural AXI memory.
// Expected bursts are pushed per command; a monitor pops them on each handshake.
module tb_armleocpu_axi_memcpy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_src, cmd_dst;
  logic [15:0] cmd_words;
  logic        done_valid, done_err;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [3:0]  axi_arid;
  logic        axi_rvalid, axi_rready;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [3:0]  axi_awid;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [3:0]  axi_bid;

  always #5 clk = ~clk;

  armleocpu_axi_memcpy #(
    .ADDR_WIDTH(32),
    .ID_WIDTH(4),
    .AXI_ID(3),
    .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_words(cmd_words),
    .done_valid(done_valid), .done_err(done_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awid(axi_awid),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_bresp(axi_bresp), .axi_bid(axi_bid)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aexp_t;

  aexp_t       exp_ar[$];
  aexp_t       exp_aw[$];
  logic [32:0] exp_w[$];
  logic        exp_done[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int w_seen = 0;
  int r_cnt, b_cnt, r_err_at, b_err_at;
  bit stall_en;
  logic [31:0] wmem [logic [31:0]];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: actual=%h required=no transfer", name, act);
  endtask

  task automatic expect_chunk(input logic [31:0] s, input logic [31:0] d,
                              input int n, input bit wr);
    exp_ar.push_back({s, 8'(n - 1)});
    if (wr) begin
      exp_aw.push_back({d, 8'(n - 1)});
      for (int i = 0; i < n; i++)
        exp_w.push_back({pat(s + 32'(4 * i)), i == n - 1});
    end
  endtask

  // AXI memory responder: drives at negedge, decides fires for the next posedge
  initial begin : slave
    logic        ar_f, r_f, aw_f, w_f, b_f, w_l, rd_act, b_pend;
    logic [31:0] ar_a, aw_a, w_d, rd_addr, wr_addr;
    logic [7:0]  ar_l;
    int          rd_left;
    ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0; w_l = 0;
    rd_act = 0; b_pend = 0; ar_a = 0; aw_a = 0; w_d = 0;
    rd_addr = 0; wr_addr = 0; ar_l = 0; rd_left = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rresp = 0; axi_rlast = 0;
    axi_rdata = 0; axi_rid = 4'd3; axi_awready = 0; axi_wready = 0;
    axi_bvalid = 0; axi_bresp = 0; axi_bid = 4'd3;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
        rd_act = 0; b_pend = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
      end else begin
        if (ar_f) begin
          rd_addr = ar_a;
          rd_left = int'(ar_l) + 1;
          rd_act = 1;
        end
        if (r_f) begin
          rd_addr += 4;
          rd_left--;
          r_cnt++;
          if (rd_left == 0) rd_act = 0;
        end
        if (aw_f) wr_addr = aw_a;
        if (w_f) begin
          wmem[wr_addr] = w_d;
          wr_addr += 4;
          if (w_l) b_pend = 1;
        end
        if (b_f) begin
          b_pend = 0;
          b_cnt++;
        end
        axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        axi_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!axi_rvalid || r_f) begin
          axi_rvalid = rd_act && (!stall_en || $urandom_range(0, 1) == 1);
          axi_rdata  = pat(rd_addr);
          axi_rlast  = (rd_left == 1);
          axi_rresp  = (r_cnt == r_err_at) ? 2'b11 : 2'b00;
        end
        if (!axi_bvalid || b_f) begin
          axi_bvalid = b_pend && (!stall_en || $urandom_range(0, 1) == 1);
          axi_bresp  = (b_cnt == b_err_at) ? 2'b10 : 2'b00;
        end
        ar_f = axi_arvalid && axi_arready;
        ar_a = axi_araddr;
        ar_l = axi_arlen;
        r_f  = axi_rvalid && axi_rready;
        aw_f = axi_awvalid && axi_awready;
        aw_a = axi_awaddr;
        w_f  = axi_wvalid && axi_wready;
        w_d  = axi_wdata;
        w_l  = axi_wlast;
        b_f  = axi_bvalid && axi_bready;
      end
    end
  end

  initial begin : monitor
    logic        ar_h, aw_h, w_h;
    logic [39:0] ar_p, aw_p;
    logic [32:0] w_p;
    aexp_t       e;
    logic [32:0] ew;
    ar_h = 0; aw_h = 0; w_h = 0; ar_p = 0; aw_p = 0; w_p = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        ar_h = 0; aw_h = 0; w_h = 0;
      end else begin
        if (ar_h)
          check("ar_stable", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, ar_p});
        if (aw_h)
          check("aw_stable", {axi_awvalid, axi_awaddr, axi_awlen}, {1'b1, aw_p});
        if (w_h)
          check("w_stable", {axi_wvalid, axi_wdata, axi_wlast}, {1'b1, w_p});
        if (axi_arvalid && axi_arready) begin
          if (exp_ar.size() == 0) unexpected("ar_unexpected", {axi_araddr, axi_arlen});
          else begin
            e = exp_ar.pop_front();
            check("ar", {axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid},
                  {e.addr, e.len, 3'd2, 2'b01, 4'd3});
          end
        end
        if (axi_awvalid && axi_awready) begin
          if (exp_aw.size() == 0) unexpected("aw_unexpected", {axi_awaddr, axi_awlen});
          else begin
            e = exp_aw.pop_front();
            check("aw", {axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid},
                  {e.addr, e.len, 3'd2, 2'b01, 4'd3});
          end
        end
        if (axi_wvalid && axi_wready) begin
          w_seen++;
          if (exp_w.size() == 0) unexpected("w_unexpected", {axi_wdata, axi_wlast});
          else begin
            ew = exp_w.pop_front();
            check("w", {axi_wdata, axi_wlast, axi_wstrb}, {ew, 4'hF});
          end
        end
        if (done_valid) begin
          done_cnt++;
          if (exp_done.size() == 0) unexpected("done_unexpected", 64'(done_err));
          else check("done_err", 64'(done_err), 64'(exp_done.pop_front()));
        end
        ar_h = axi_arvalid && !axi_arready;
        ar_p = {axi_araddr, axi_arlen};
        aw_h = axi_awvalid && !axi_awready;
        aw_p = {axi_awaddr, axi_awlen};
        w_h  = axi_wvalid && !axi_wready;
        w_p  = {axi_wdata, axi_wlast};
      end
    end
  end

  task automatic issue(input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] n);
    int k;
    k = 0;
    r_cnt = 0;
    b_cnt = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) unexpected("cmd_ready_timeout", 64'(k));
    cmd_src = s;
    cmd_dst = d;
    cmd_words = n;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_latency", {axi_arvalid, done_valid, cmd_ready},
          (n != 16'd0) ? 3'b100 : 3'b010);
  endtask

  task automatic wait_done(input int start);
    int k;
    k = 0;
    while (done_cnt == start && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=no done_valid required=done_valid");
    end
    @(negedge clk);
    check("drain", {16'(exp_ar.size()), 16'(exp_aw.size()),
                    16'(exp_w.size()), 16'(exp_done.size())}, 64'd0);
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n);
    int st;
    st = done_cnt;
    issue(s, d, n);
    wait_done(st);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, k;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_words = '0;
    stall_en = 0;
    r_err_at = -1;
    b_err_at = -1;
    r_cnt = 0;
    b_cnt = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", {cmd_ready, done_valid, done_err, axi_arvalid,
                         axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 8'h00);
    rst_n = 1'b1;

    // single short burst
    expect_chunk(32'h100, 32'h800, 5, 1);
    exp_done.push_back(1'b0);
    run(32'h100, 32'h800, 16'd5);
    check("t1_mem0", rdmem(32'h800), 32'hFEFF_0100);
    check("t1_mem4", rdmem(32'h810), 32'hFEEF_0110);
    for (int i = 1; i < 4; i++)
      check("t1_mem", rdmem(32'h800 + 32'(4 * i)), pat(32'h100 + 32'(4 * i)));

    // three chunks 16/16/8
    expect_chunk(32'h1000, 32'h4000, 16, 1);
    expect_chunk(32'h1040, 32'h4040, 16, 1);
    expect_chunk(32'h1080, 32'h4080, 8, 1);
    exp_done.push_back(1'b0);
    run(32'h1000, 32'h4000, 16'd40);
    check("t2_mem_last", rdmem(32'h409C), pat(32'h109C));

    // read error on beat 2: no write, error done
    r_err_at = 2;
    expect_chunk(32'h200, 32'h900, 8, 0);
    exp_done.push_back(1'b1);
    run(32'h200, 32'h900, 16'd8);
    r_err_at = -1;

    // write response error on first chunk: no second AR
    b_err_at = 0;
    expect_chunk(32'h300, 32'hA00, 16, 1);
    exp_done.push_back(1'b1);
    run(32'h300, 32'hA00, 16'd32);
    b_err_at = -1;

    // random stalls on every channel
    stall_en = 1;
    expect_chunk(32'h400, 32'hC00, 16, 1);
    expect_chunk(32'h440, 32'hC40, 4, 1);
    exp_done.push_back(1'b0);
    run(32'h400, 32'hC00, 16'd20);
    stall_en = 0;

    // zero-length command
    exp_done.push_back(1'b0);
    run(32'h10, 32'h20, 16'd0);

    // reset in the middle of the write burst
    expect_chunk(32'h500, 32'hD00, 16, 1);
    base = w_seen;
    issue(32'h500, 32'hD00, 16'd16);
    k = 0;
    while (w_seen < base + 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("pre_reset_wvalid", 64'(axi_wvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {cmd_ready, done_valid, done_err, axi_arvalid,
                             axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 8'h00);
    exp_ar.delete();
    exp_aw.delete();
    exp_w.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_chunk(32'h600, 32'hE00, 3, 1);
    exp_done.push_back(1'b0);
    run(32'h600, 32'hE00, 16'd3);
    check("t7_mem2", rdmem(32'hE08), pat(32'h608));

`ifdef ARMLEOCPU_MEMCPY_4K_SPLIT_EN
    expect_chunk(32'hFF8, 32'h2000, 2, 1);
    expect_chunk(32'h1000, 32'h2008, 4, 1);
    exp_done.push_back(1'b0);
    run(32'hFF8, 32'h2000, 16'd6);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
